// File: rtl/irom_boot_loader_if.sv
// Byte-stream handshake and IROM write port bundle for the boot loader.
// The loader takes the slave view; the byte source and IROM side take the master view.
interface irom_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              irom_we;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, irom_we, irom_addr, irom_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, irom_we, irom_addr, irom_wdata
    );
endinterface

// File: rtl/irom_boot_loader.sv
// Boot sequencer: takes a length-prefixed little-endian byte stream, writes it into
// IROM one word at a time, then drops setup so the core fetches from word 0.
module irom_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    irom_boot_loader_if.slave   bus,
    input  logic                i_boot_req,
    output logic                o_setup,
    output logic                o_pc_start,
    output logic                o_done,
    output logic                o_err,
    output logic [15:0]         o_words_loaded
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_W;

    logic [2:0]        r_state;
    logic [15:0]       r_len;
    logic [1:0]        r_cnt;
    logic [31:0]       r_word;
    logic [ADDR_W:0]   r_word_idx;
    logic [15:0]       r_words_loaded;
    logic              r_setup;
    logic              r_pc_start;
    logic              r_done;
    logic              r_err;
    logic              r_irom_we;
    logic [ADDR_W-1:0] r_irom_addr;
    logic [31:0]       r_irom_wdata;

    logic [2:0]  w_state_nxt;
    logic        w_in_ready;
    logic        w_accept;
    logic [15:0] w_len_nxt;
    logic [31:0] w_word_nxt;
    logic [16:0] w_idx_inc;
    logic        w_reload;

    // in_ready depends only on state (and is forced low while reset is held)
    always_comb begin
        w_in_ready = 1'b0;
        if (i_rst) begin
            w_in_ready = 1'b0;
        end else if ((r_state == IDLE) || (r_state == LEN_HI) || (r_state == DATA)) begin
            w_in_ready = 1'b1;
        end else begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_len_nxt = {bus.in_data, r_len[7:0]};
    assign w_idx_inc = 17'(r_word_idx) + 17'd1;
    assign w_reload  = i_boot_req & ((r_state == RUN) || (r_state == ERR));

    // Drop the incoming byte into its lane of the word being assembled
    always_comb begin
        w_word_nxt = r_word;
        case (r_cnt)
            2'd0:    w_word_nxt[7:0]   = bus.in_data;
            2'd1:    w_word_nxt[15:8]  = bus.in_data;
            2'd2:    w_word_nxt[23:16] = bus.in_data;
            2'd3:    w_word_nxt[31:24] = bus.in_data;
            default: w_word_nxt = r_word;
        endcase
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = LEN_HI;
                else          w_state_nxt = IDLE;
            end
            LEN_HI: begin
                if (!w_accept)                       w_state_nxt = LEN_HI;
                else if (w_len_nxt == 16'd0)         w_state_nxt = RUN;
                else if ({1'b0, w_len_nxt} > DEPTH_C) w_state_nxt = ERR;
                else                                 w_state_nxt = DATA;
            end
            DATA: begin
                if (w_accept && (r_cnt == 2'd3)) w_state_nxt = WRITE;
                else                             w_state_nxt = DATA;
            end
            WRITE: begin
                if (w_idx_inc == {1'b0, r_len}) w_state_nxt = RUN;
                else                            w_state_nxt = DATA;
            end
            RUN: begin
                if (i_boot_req) w_state_nxt = IDLE;
                else            w_state_nxt = RUN;
            end
            ERR: begin
                if (i_boot_req) w_state_nxt = IDLE;
                else            w_state_nxt = ERR;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_len          <= 16'd0;
            r_cnt          <= 2'd0;
            r_word         <= 32'd0;
            r_word_idx     <= '0;
            r_words_loaded <= 16'd0;
            r_setup        <= 1'b1;
            r_pc_start     <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_irom_we      <= 1'b0;
            r_irom_addr    <= '0;
            r_irom_wdata   <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_setup    <= (w_state_nxt != RUN);
            r_done     <= (w_state_nxt == RUN);
            r_err      <= (w_state_nxt == ERR);
            r_pc_start <= (w_state_nxt == RUN) && (r_state != RUN);
            r_irom_we  <= (w_state_nxt == WRITE);
            case (r_state)
                IDLE: begin
                    if (w_accept) r_len <= {8'h00, bus.in_data};
                end
                LEN_HI: begin
                    if (w_accept) r_len <= w_len_nxt;
                end
                DATA: begin
                    if (w_accept) begin
                        r_word <= w_word_nxt;
                        r_cnt  <= r_cnt + 2'd1;
                    end
                    // Capture address/data with the final byte so the strobe cycle is clean
                    if (w_accept && (r_cnt == 2'd3)) begin
                        r_irom_addr  <= r_word_idx[ADDR_W-1:0];
                        r_irom_wdata <= w_word_nxt;
                    end
                end
                WRITE: begin
                    r_word_idx     <= r_word_idx + 1'b1;
                    r_words_loaded <= r_words_loaded + 16'd1;
                end
                default: begin
                    if (w_reload) begin
                        r_cnt          <= 2'd0;
                        r_word_idx     <= '0;
                        r_words_loaded <= 16'd0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.irom_we    = r_irom_we;
    assign bus.irom_addr  = r_irom_addr;
    assign bus.irom_wdata = r_irom_wdata;
    assign o_setup        = r_setup;
    assign o_pc_start     = r_pc_start;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_words_loaded = r_words_loaded;
endmodule
